dbuf_swap_ctrl: RTL

DBUF_SWAP_CTRL -- requirements
Module: dbuf_swap_ctrl

---
 rtl/dbuf_swap_if.sv | 34 +++
 rtl/dbuf_swap_ctrl.sv | 87 ++++++++
 2 files changed

// File: rtl/dbuf_swap_if.sv
// Handshake/status bundle between the double-buffer controller, timing generator,
// scanout loader and drawing engine. drop_count exists only with DBUF_DROP_COUNT_EN.
interface dbuf_swap_if #(parameter int LINE_W = 10);
  logic              frame_start;
  logic              line_req;
  logic              draw_req;
  logic              draw_done;
  logic              draw_grant;
  logic              front_sel;
  logic [LINE_W-1:0] hline_sel;
  logic              line_load;
  logic [7:0]        swap_count;
`ifdef DBUF_DROP_COUNT_EN
  logic [7:0]        drop_count;

  modport slave (
    input  frame_start, line_req, draw_req, draw_done,
    output draw_grant, front_sel, hline_sel, line_load, swap_count, drop_count
  );
  modport master (
    output frame_start, line_req, draw_req, draw_done,
    input  draw_grant, front_sel, hline_sel, line_load, swap_count, drop_count
  );
`else
  modport slave (
    input  frame_start, line_req, draw_req, draw_done,
    output draw_grant, front_sel, hline_sel, line_load, swap_count
  );
  modport master (
    output frame_start, line_req, draw_req, draw_done,
    input  draw_grant, front_sel, hline_sel, line_load, swap_count
  );
`endif
endinterface

// File: rtl/dbuf_swap_ctrl.sv
// Front/back buffer swap controller with scanout line sequencer.
// Optional repeated-frame counter enabled by defining DBUF_DROP_COUNT_EN.
module dbuf_swap_ctrl #(
  parameter int HEIGHT = 480,
  parameter int LINE_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  dbuf_swap_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DRAW, READY, SWAP} state_e;

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(HEIGHT - 1);

  state_e            state_q, state_d;
  logic              grant_q;
  logic              front_q;
  logic [7:0]        swap_cnt_q;
  logic [LINE_W-1:0] hline_q, hline_d;
  logic              load_q, load_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.draw_req)    state_d = DRAW;
      DRAW:    if (bus.draw_done)   state_d = READY;
      READY:   if (bus.frame_start) state_d = SWAP;
      SWAP:                         state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Index advances the cycle after its strobe, so the loader sees a stable index.
  always_comb begin
    hline_d = hline_q;
    load_d  = 1'b0;
    if (bus.frame_start) begin
      hline_d = '0;
    end else begin
      if (load_q) hline_d = (hline_q == LAST_LINE) ? '0 : hline_q + 1'b1;
      load_d = bus.line_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      front_q    <= 1'b0;
      swap_cnt_q <= '0;
      hline_q    <= '0;
      load_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= (state_d == DRAW);
      hline_q <= hline_d;
      load_q  <= load_d;
      if (state_q == SWAP) begin
        front_q    <= ~front_q;
        swap_cnt_q <= swap_cnt_q + 8'd1;
      end
    end
  end

`ifdef DBUF_DROP_COUNT_EN
  logic [7:0] drop_q;

  // A frame_start before the back buffer is ready means the front frame repeats.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (bus.frame_start && (state_q == IDLE || state_q == DRAW) && drop_q != 8'hFF) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.drop_count = drop_q;
`endif

  assign bus.draw_grant = grant_q;
  assign bus.front_sel  = front_q;
  assign bus.swap_count = swap_cnt_q;
  assign bus.hline_sel  = hline_q;
  assign bus.line_load  = load_q;

endmodule
